reset_halt_ctrl: RTL

Parametrised board-level reset and run-control sequencer for the Tang Nano CPU/DVI builds. It synchronises and debounces the active-low reset button and the PLL lock input, then releases an N-stage reset vector in fixed order with a programmable gap between stages. It also owns the CPU halt-on-exit latch, adding resume and a clock-enable output. This replaces the ad-hoc button shift register, cascaded reset sequencers and halt flop in the board top files.

---
 rtl/reset_halt_ctrl_if.sv | 24 ++
 rtl/reset_halt_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reset_halt_ctrl_if.sv
// reset_halt_ctrl_if: board-level reset/run-control signal bundle.
// master drives the raw board inputs, slave is the sequencer.
interface reset_halt_ctrl_if #(
   parameter int NUM_STAGES = 3
);
   logic                  button_n;
   logic                  lock_in;
   logic                  exit_in;
   logic                  resume;
   logic [NUM_STAGES-1:0] reset_out;
   logic                  halt;
   logic                  clock_enable;
   logic                  lock_lost;

   modport master (
      output button_n, lock_in, exit_in, resume,
      input  reset_out, halt, clock_enable, lock_lost
   );

   modport slave (
      input  button_n, lock_in, exit_in, resume,
      output reset_out, halt, clock_enable, lock_lost
   );
endinterface

// File: rtl/reset_halt_ctrl.sv
// reset_halt_ctrl: button/PLL-lock reset sequencer with staged
// release, CPU halt latch and clock enable.
module reset_halt_ctrl #(
   parameter int NUM_STAGES         = 3,
   parameter int STAGE_DELAY_CYCLES = 16,
   parameter int DEBOUNCE_CYCLES    = 1024,
   parameter int SYNC_STAGES        = 3
) (
   input  logic             clock,
   input  logic             reset,
   reset_halt_ctrl_if.slave io
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CW = (STAGE_DELAY_CYCLES > 1) ?
                       $clog2(STAGE_DELAY_CYCLES) : 1;
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_DELAY_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_RELEASE,
      ST_RUN
   } state_t;

   logic [SYNC_STAGES-1:0] btn_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   btn_s;
   logic                   lock_s;

   logic [DW-1:0]          db_cnt_q, db_cnt_d;
   logic                   btn_acc_q, btn_acc_d;
   logic                   pressed;
   logic                   req;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_STAGES-1:0]  rst_q, rst_d;
   logic                   halt_q, halt_d;
   logic                   ce_q, ce_d;
   logic                   ll_q, ll_d;

   assign btn_s   = btn_sync_q[SYNC_STAGES-1];
   assign lock_s  = lock_sync_q[SYNC_STAGES-1];
   assign pressed = ~btn_acc_q;
   assign req     = reset | pressed | ~lock_s;

   // Bring the raw button and lock pins into the clock domain.
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_sync_q  <= '1;
         lock_sync_q <= '0;
      end else begin
         btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], io.button_n};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], io.lock_in};
      end
   end

   // Accept a new button level only after it has held long enough.
   always_comb begin
      db_cnt_d  = '0;
      btn_acc_d = btn_acc_q;
      if (btn_s != btn_acc_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_acc_d = btn_s;
         end else begin
            db_cnt_d = db_cnt_q + DW'(1);
         end
      end
   end

   // Staged release sequence plus halt, enable and lock-loss flags.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      if (req) begin
         state_d = ST_ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '1;
      end else begin
         unique case (state_q)
            ST_ASSERT, ST_RELEASE: begin
               state_d = ST_RELEASE;
               if (cnt_q == CNT_LAST) begin
                  cnt_d        = '0;
                  rst_d[idx_q] = 1'b0;
                  idx_d        = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
                     state_d = ST_RUN;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               rst_d = '0;
            end
            default: begin
               state_d = ST_ASSERT;
            end
         endcase
      end

      halt_d = halt_q;
      if (req) begin
         halt_d = 1'b0;
      end else if (state_q == ST_RUN && io.exit_in) begin
         halt_d = 1'b1;
      end else if (io.resume) begin
         halt_d = 1'b0;
      end

      ce_d = (state_d == ST_RUN) & ~halt_d;

      ll_d = ll_q;
      if (~lock_s && state_q != ST_ASSERT) begin
         ll_d = 1'b1;
      end else if (pressed) begin
         ll_d = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         db_cnt_q  <= '0;
         btn_acc_q <= 1'b1;
         state_q   <= ST_ASSERT;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_q     <= '1;
         halt_q    <= 1'b0;
         ce_q      <= 1'b0;
         ll_q      <= 1'b0;
      end else begin
         db_cnt_q  <= db_cnt_d;
         btn_acc_q <= btn_acc_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_q     <= rst_d;
         halt_q    <= halt_d;
         ce_q      <= ce_d;
         ll_q      <= ll_d;
      end
   end

   assign io.reset_out    = rst_q;
   assign io.halt         = halt_q;
   assign io.clock_enable = ce_q;
   assign io.lock_lost    = ll_q;

endmodule
